// File: rtl/iq_pair_sequencer.sv
// rtl/iq_pair_sequencer.sv - serialises a captured frame of I/Q pairs one pair per beat,
// in forward or reverse order, with a zero-bubble hand-off between back-to-back frames.
module iq_pair_sequencer #(
  parameter int W     = 5,
  parameter int NPAIR = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*W*NPAIR-1:0]   in_data,
  input  logic                   in_rev,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_i,
  output logic [W-1:0]           out_q,
  output logic [((NPAIR <= 2) ? 1 : $clog2(NPAIR))-1:0] out_idx,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int IDXW = (NPAIR <= 2) ? 1 : $clog2(NPAIR);
  localparam logic [IDXW-1:0] LAST_POS = IDXW'(NPAIR - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        pos_q, pos_d;
  logic [2*W*NPAIR-1:0]   frame_q, frame_d;
  logic                   rev_q, rev_d;

  logic                   sending;
  logic                   at_last;
  logic                   in_hs;
  logic                   out_hs;
  logic [IDXW-1:0]        idx;
  logic [2*W-1:0]         pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      frame_q <= '0;
      rev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      frame_q <= frame_d;
      rev_q   <= rev_d;
    end
  end

  always_comb begin
    sending  = (state_q == SEND);
    at_last  = (pos_q == LAST_POS);
    idx      = rev_q ? (LAST_POS - pos_q) : pos_q;
    in_ready = !sending || (at_last && out_ready);
    in_hs    = in_valid && in_ready;
    out_hs   = sending && out_ready;

    // Mux out the selected pair without a variable part-select on a computed offset.
    pair = '0;
    for (int k = 0; k < NPAIR; k++) begin
      if (idx == IDXW'(k)) pair = frame_q[2*W*k +: 2*W];
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    frame_d = frame_q;
    rev_d   = rev_q;
    if (in_hs) begin
      // Covers both the idle start and the last-beat overlap with a new frame.
      state_d = SEND;
      pos_d   = '0;
      frame_d = in_data;
      rev_d   = in_rev;
    end else if (out_hs && at_last) begin
      state_d = IDLE;
      pos_d   = '0;
    end else if (out_hs) begin
      pos_d = pos_q + 1'b1;
    end
  end

  always_comb begin
    out_valid = sending;
    out_i     = '0;
    out_q     = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (sending) begin
      out_i    = pair[W-1:0];
      out_q    = pair[2*W-1:W];
      out_idx  = idx;
      out_last = at_last;
    end
  end

endmodule

// File: tb/tb_iq_pair_sequencer.sv
// tb/tb_iq_pair_sequencer.sv - directed scoreboard bench for iq_pair_sequencer.
module tb_iq_pair_sequencer;

  localparam int W     = 5;
  localparam int NPAIR = 5;
  localparam int IDXW  = 3;
  localparam int FW    = 2*W*NPAIR;

  logic            clk = 1'b0;
  logic            rst;
  logic [FW-1:0]   in_data;
  logic            in_rev;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_i;
  logic [W-1:0]    out_q;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  int errors = 0;
  int checks = 0;

  // Entry layout: {idx, last, i, q}
  logic [IDXW+1+2*W-1:0] sb[$];

  iq_pair_sequencer #(.W(W), .NPAIR(NPAIR)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_rev(in_rev), .in_valid(in_valid), .in_ready(in_ready),
    .out_i(out_i), .out_q(out_q), .out_idx(out_idx), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] ramp_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NPAIR; k++) begin
      f[2*W*k +: W]     = W'(2*k);
      f[2*W*k + W +: W] = W'(2*k + 1);
    end
    return f;
  endfunction

  function automatic logic [FW-1:0] const_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NPAIR; k++) begin
      f[2*W*k +: W]     = W'(31);
      f[2*W*k + W +: W] = W'(30);
    end
    return f;
  endfunction

  task automatic push_frame(input logic [FW-1:0] f, input logic rev);
    int idx;
    for (int p = 0; p < NPAIR; p++) begin
      idx = rev ? (NPAIR - 1 - p) : p;
      sb.push_back({IDXW'(idx), (p == NPAIR - 1), f[2*W*idx +: W], f[2*W*idx + W +: W]});
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1 time unit later.
  task automatic tick();
    logic [IDXW+1+2*W-1:0] exp;
    #1;
    if (!out_valid) begin
      chk("idle_outputs_zero", {out_i, out_q, out_idx, out_last}, 32'd0);
      chk("idle_in_ready", in_ready, 1);
    end else if (sb.size() == 0) begin
      chk("unexpected_pair", {out_idx, out_last, out_i, out_q}, 32'hffffffff);
    end else begin
      exp = sb[0];
      chk("pair", {out_idx, out_last, out_i, out_q}, exp);
      chk("send_in_ready", in_ready, exp[2*W] && out_ready);
      if (out_ready) void'(sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
    chk("drained", sb.size(), 0);
  endtask

  task automatic offer(input logic [FW-1:0] f, input logic rev);
    in_data  = f;
    in_rev   = rev;
    in_valid = 1'b1;
    push_frame(f, rev);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_rev = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {out_i, out_q, out_idx, out_last}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Forward frame, then confirm return to idle.
    offer(ramp_frame(), 1'b0);
    drain(NPAIR);
    tick();

    // Reverse frame.
    offer(ramp_frame(), 1'b1);
    drain(NPAIR);
    tick();

    // Backpressure on idx2 with in_data toggling.
    offer(ramp_frame(), 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_data = {FW{s[0]}};
      tick();
      chk("stall_idx", out_idx, 2);
    end
    out_ready = 1'b1;
    drain(3);
    tick();

    // Back-to-back frames with in_valid held high.
    in_data  = ramp_frame();
    in_rev   = 1'b0;
    in_valid = 1'b1;
    push_frame(ramp_frame(), 1'b0);
    tick();
    in_data = const_frame();
    push_frame(const_frame(), 1'b0);
    repeat (NPAIR) tick();
    in_valid = 1'b0;
    drain(NPAIR);
    tick();

    // Reset pulse while idx2 is presented.
    offer(ramp_frame(), 1'b0);
    tick();
    tick();
    chk("pre_reset_idx", out_idx, 2);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_outputs", {out_i, out_q, out_idx, out_last}, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    offer(ramp_frame(), 1'b1);
    drain(NPAIR);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iq_pair_sequencer.md
IQ_PAIR_SEQUENCER -- requirements
Module: iq_pair_sequencer

Interface
REQ-001 SHALL have parameter W, default 5, sample width in bits of each I and Q word.
REQ-002 SHALL have parameter NPAIR, default 5, number of I/Q pairs per frame (legal range 2..16).
REQ-003 SHALL derive IDXW = max(1, ceil(log2(NPAIR))) internally; IDXW is not overridable.
REQ-004 One clock; reset is asynchronous and active-high: port clk, input, 1, rising-edge clock for all state.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port in_data, input, 2*W*NPAIR, frame; pair k occupies bits [2*W*k +: 2*W], with I in the lower W bits and Q in the upper W bits.
REQ-007 Port in_rev, input, 1, order mode; sampled with the frame (0 = pair 0 first, 1 = pair NPAIR-1 first).
REQ-008 Port in_valid, input, 1, frame offered.
REQ-009 Port in_ready, output, 1, frame accepted when in_valid && in_ready.
REQ-010 Port out_i, output, W, I word of the current pair.
REQ-011 Port out_q, output, W, Q word of the current pair.
REQ-012 Port out_idx, output, IDXW, pair index k of the current pair.
REQ-013 Port out_last, output, 1, current pair is the final pair of the frame.
REQ-014 Port out_valid, output, 1, pair presented.
REQ-015 Port out_ready, input, 1, downstream accepts the pair when out_valid && out_ready.

Function
REQ-016 SHALL implement the two states IDLE and SEND.
REQ-017 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In SEND, out_valid SHALL be 1.
- in_ready SHALL be 1 only on the last beat, when out_last && out_ready.
- in_ready SHALL be a combinational function of state, position and out_ready.
REQ-019 On an input handshake, the block SHALL capture in_data and in_rev into a frame register, enter SEND, and set position 0. The first pair SHALL appear on the next cycle (latency 1 cycle).
REQ-020 Position-to-index mapping:
- out_idx = position when rev = 0.
- out_idx = NPAIR-1-position when rev = 1.
- out_i/out_q SHALL be the captured pair at out_idx.
REQ-021 On each output handshake that is not the last beat, position SHALL increment by 1.
REQ-022 out_last SHALL be 1 iff position == NPAIR-1.
REQ-023 While out_valid && !out_ready, out_i, out_q, out_idx and out_last SHALL hold stable. Input changes SHALL have no effect on them.
REQ-024 Last-beat handshake without a simultaneous input handshake:
- go to IDLE; position resets to 0.
REQ-025 Last-beat handshake with a simultaneous input handshake:
- capture the new frame, remain in SEND, reset position to 0.
- no bubble cycle occurs between frames.
REQ-026 When out_valid = 0, out_i, out_q, out_idx and out_last SHALL all be driven 0.
REQ-027 Position SHALL never exceed NPAIR-1. Wrap to 0 occurs only via REQ-024 or REQ-025.
REQ-028 in_data changes while in SEND SHALL NOT alter the frame being sent.
REQ-029 The design SHALL be fully synchronous apart from rst, and SHALL contain no latches.

Reset
REQ-030 While rst = 1, and on the first clk edge after release:
- state = IDLE, position = 0, frame register = 0, rev = 0.
- in_ready = 1, out_valid = 0, out_i/out_q/out_idx/out_last = 0.
REQ-031 Assertion of rst mid-frame SHALL abort the frame immediately (asynchronously). No remaining pairs SHALL be emitted after release.

Verification
REQ-032 Forward frame: W=5, NPAIR=5, pairs k = (I=2k, Q=2k+1), rev=0, out_ready=1. Required response:
- outputs over 5 consecutive cycles: (0,1) idx0, (2,3) idx1, (4,5) idx2, (6,7) idx3, (8,9) idx4.
- out_last = 1 only on idx4, then return to IDLE.
REQ-033 Reverse frame: same data, rev=1. Required response:
- idx sequence 4,3,2,1,0 with (8,9) first.
- out_last = 1 on idx0.
REQ-034 Backpressure: out_ready=0 for 3 cycles while presenting idx2. Required response:
- (4,5)/idx2 held for 4 cycles.
- in_data toggled during the stall SHALL have no effect.
REQ-035 Back-to-back: in_valid held high with a second frame (I=31, Q=30 in all pairs). Required response:
- second frame idx0 follows first frame idx4 on the very next cycle.
- in_ready = 1 only on that last beat.
REQ-036 Reset mid-frame: rst pulsed while presenting idx2. Required response:
- out_valid drops to 0 immediately and in_ready = 1.
- the next frame starts at idx0.
